// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus between the fetch unit (master) and a
// synchronous instruction memory (slave).
interface instr_fetch_if #(
    parameter int AW = 12,
    parameter int IW = 8
);
    logic [AW-1:0] imem_addr;
    logic          imem_rd_en;
    logic [IW-1:0] imem_rdata;

    modport master (output imem_addr, output imem_rd_en, input imem_rdata);
    modport slave  (input imem_addr, input imem_rd_en, output imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads synchronous imem at the PC and loads the IR.
// Optional one-entry next-line prefetch buffer: define INSTR_FETCH_PREFETCH_EN.
module instr_fetch #(
    parameter int AW      = 12,
    parameter int IW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_pc_addr,
    input  logic          i_fetch_req,
    input  logic          i_flush,
    instr_fetch_if.master imem,
    output logic [IW-1:0] o_ir,
    output logic          o_ir_valid,
    output logic          o_fetch_done,
    output logic          o_pc_inc_en,
    output logic          o_busy
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_badLat
            $error("instr_fetch: MEM_LAT must be in 1..4");
        end
    endgenerate

    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [AW-1:0] r_addrQ;
    logic [AW-1:0] r_imemAddr;
    logic          r_rdEn;
    logic [1:0]    r_count;
    logic [IW-1:0] r_ir;
    logic          r_irValid;

`ifdef INSTR_FETCH_PREFETCH_EN
    logic          r_pfValid;
    logic          r_pfIssue;
    logic          r_pfWait;
    logic [AW-1:0] r_pfAddr;
    logic [IW-1:0] r_pfData;
    logic          w_canStart;
    logic          w_pfHit;

    // A request must wait for an outstanding speculative read before hit-checking.
    assign w_canStart = !r_pfIssue && !r_pfWait;
    assign w_pfHit    = r_pfValid && (i_pc_addr == r_pfAddr);
`endif

    assign imem.imem_addr  = r_imemAddr;
    assign imem.imem_rd_en = r_rdEn;
    assign o_ir            = r_ir;
    assign o_ir_valid      = r_irValid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (i_flush) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
`ifdef INSTR_FETCH_PREFETCH_EN
                    if (i_fetch_req && w_canStart) w_nextState = w_pfHit ? DONE : ISSUE;
`else
                    if (i_fetch_req) w_nextState = ISSUE;
`endif
                end
                ISSUE:   w_nextState = WAIT;
                WAIT:    if (r_count == 2'd0) w_nextState = DONE;
                DONE:    w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Flush gating keeps a redirecting PC write from being overridden by the increment.
    always_comb begin
        o_busy       = (r_state != IDLE);
        o_fetch_done = (r_state == DONE) && !i_flush;
        o_pc_inc_en  = (r_state == DONE) && !i_flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addrQ    <= '0;
            r_imemAddr <= '0;
            r_rdEn     <= 1'b0;
            r_count    <= 2'd0;
            r_ir       <= '0;
            r_irValid  <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
            r_pfValid  <= 1'b0;
            r_pfIssue  <= 1'b0;
            r_pfWait   <= 1'b0;
            r_pfAddr   <= '0;
            r_pfData   <= '0;
`endif
        end else if (i_flush) begin
            r_rdEn    <= 1'b0;
            r_irValid <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
            r_pfValid <= 1'b0;
            r_pfIssue <= 1'b0;
            r_pfWait  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
`ifdef INSTR_FETCH_PREFETCH_EN
                    if (i_fetch_req && w_canStart) begin
                        r_addrQ   <= i_pc_addr;
                        r_pfValid <= 1'b0;
                        if (w_pfHit) begin
                            r_ir      <= r_pfData;
                            r_irValid <= 1'b1;
                        end else begin
                            r_imemAddr <= i_pc_addr;
                            r_rdEn     <= 1'b1;
                            r_irValid  <= 1'b0;
                        end
                    end else if (r_pfIssue) begin
                        r_rdEn    <= 1'b0;
                        r_count   <= LAT_INIT;
                        r_pfIssue <= 1'b0;
                        r_pfWait  <= 1'b1;
                    end else if (r_pfWait) begin
                        if (r_count != 2'd0) begin
                            r_count <= r_count - 2'd1;
                        end else begin
                            r_pfData  <= imem.imem_rdata;
                            r_pfValid <= 1'b1;
                            r_pfWait  <= 1'b0;
                        end
                    end
`else
                    if (i_fetch_req) begin
                        r_addrQ    <= i_pc_addr;
                        r_imemAddr <= i_pc_addr;
                        r_rdEn     <= 1'b1;
                        r_irValid  <= 1'b0;
                    end
`endif
                end
                ISSUE: begin
                    r_rdEn  <= 1'b0;
                    r_count <= LAT_INIT;
                end
                WAIT: begin
                    if (r_count != 2'd0) begin
                        r_count <= r_count - 2'd1;
                    end else begin
                        r_ir      <= imem.imem_rdata;
                        r_irValid <= 1'b1;
                    end
                end
                DONE: begin
`ifdef INSTR_FETCH_PREFETCH_EN
                    // Speculatively read the next sequential word; AW-bit add wraps.
                    r_imemAddr <= r_addrQ + 1'b1;
                    r_pfAddr   <= r_addrQ + 1'b1;
                    r_rdEn     <= 1'b1;
                    r_pfIssue  <= 1'b1;
                    r_pfValid  <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Downstream consumer of the program counter in the single-core processor.
- Takes the 12-bit PC value, issues a read to synchronous instruction memory, and captures the returned word into the instruction register.
- Returns a one-cycle increment pulse to the PC's inc_en and a completion pulse to the control unit.
- A flush input lets the control unit abandon a fetch when it redirects the PC on a jump.

Parameters:
- AW, 12: address width; matches the PC output width.
- IW, 8: instruction word width, i.e. the width of imem_rdata and ir.
- MEM_LAT, 1: cycles from the imem_rd_en sampling edge to valid imem_rdata. Legal range 1..4; anything else is an elaboration error.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_addr  in  AW  current PC value.
- fetch_req  in  1  fetch request from the control unit; level, sampled in IDLE only.
- flush  in  1  abandon the in-flight fetch; highest priority.
- imem_addr  out  AW  instruction memory address, registered.
- imem_rd_en  out  1  instruction memory read strobe, registered, one cycle per read.
- imem_rdata  in  IW  instruction memory read data.
- ir  out  IW  instruction register.
- ir_valid  out  1  ir holds the result of the latest completed fetch.
- fetch_done  out  1  one-cycle completion pulse.
- pc_inc_en  out  1  one-cycle increment pulse to the PC.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - state=IDLE.
  - imem_addr=0, imem_rd_en=0, ir=0, ir_valid=0, fetch_done=0, pc_inc_en=0, busy=0.
  - Latency counter=0; internal address register addr_q=0.
  - Deassertion mid-fetch leaves the unit in IDLE; no stale capture occurs.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, at an edge with fetch_req=1 and flush=0:
  - addr_q <= pc_addr, imem_addr <= pc_addr, imem_rd_en <= 1, ir_valid <= 0.
  - Go to ISSUE.
- ISSUE (one cycle; memory samples address at the end of it): imem_rd_en <= 0, counter <= MEM_LAT-1, go to WAIT.
- WAIT:
  - If counter != 0: decrement.
  - If counter == 0: ir <= imem_rdata, ir_valid <= 1, go to DONE.
- DONE (one cycle):
  - fetch_done=1 and pc_inc_en=1 for that cycle.
  - Next state is IDLE unconditionally.
  - fetch_req is not sampled in DONE, because the PC updates at the end of DONE.
- Latency: fetch_req sampled at edge E gives fetch_done high in the cycle after edge E+MEM_LAT+1.
- Throughput: at most one fetch per MEM_LAT+3 cycles when fetch_req is held high.
- flush:
  - In any state, next state is IDLE; imem_rd_en <= 0, ir_valid <= 0.
  - ir is not overwritten.
  - pc_inc_en and fetch_done are gated combinationally by !flush, so a flush in DONE suppresses both. This is required because the PC's increment overrides its write.
- flush and fetch_req together in IDLE: flush wins; no read is issued.
- Address wrap-around is the PC's concern; this block passes pc_addr through unmodified.
- imem_rdata is ignored outside the capture edge.

Optional Feature:
- Macro: INSTR_FETCH_PREFETCH_EN.
- When defined:
  - On leaving DONE, the unit issues a speculative read of addr_q+1 (mod 2^AW, so 4095 wraps to 0).
  - The result goes into a one-entry buffer (pf_data, pf_addr, pf_valid); busy stays 0 while the speculative read is outstanding.
  - Hit: a fetch_req in IDLE with pf_valid=1 and pc_addr==pf_addr copies pf_data into ir and goes directly to DONE, so fetch_done appears in the cycle after the sampling edge.
  - Miss: if pc_addr differs or the buffer is not yet valid, the buffer is discarded and a normal fetch runs. A request arriving while the speculative read is in flight waits for it and then hit-checks.
  - flush clears pf_valid and cancels any speculative capture.
- When undefined: no buffer is built; behaviour is exactly as above.

Test Plan:
- Reset: rst_n=0 mid-WAIT, then release → all outputs 0, state IDLE, no fetch_done.
- Basic fetch, MEM_LAT=1: pc_addr=0x005, imem[5]=0xA7, fetch_req=1 at edge 0 → imem_rd_en high in cycle 1 with imem_addr=0x005; ir=0xA7, ir_valid=1, fetch_done=1 and pc_inc_en=1 in cycle 3 only.
- MEM_LAT=3, fetch_req held high for 3 fetches from 0x000 with a PC model attached → ir sequence imem[0], imem[1], imem[2]; fetch_done every 6 cycles.
- Flush in WAIT: flush=1 with imem_rdata=0x3C valid → ir keeps its previous value, ir_valid=0, no pc_inc_en, state IDLE.
- Flush in DONE → pc_inc_en=0 and fetch_done=0 that cycle; PC write of 0x100 then fetch → ir=imem[0x100].
- INSTR_FETCH_PREFETCH_EN:
  - Fetch 0xFFF, then request pc_addr=0x000 → prefetch hit; fetch_done one cycle after the request.
  - Request at pc_addr=0x010 instead → miss; full MEM_LAT+2 latency.
